// File: rtl/branch_resolve_predict_unit.sv
// branch_resolve_predict_unit: registered branch/jump/xRET resolution with a bimodal BHT predictor
// and saturating branch/mispredict statistics.
package branch_decoder_unit_pkg;
    typedef enum logic [2:0] {
        NoBranch   = 3'd0,
        Mret       = 3'd1,
        Sret       = 3'd2,
        Jump       = 3'd3,
        CondBranch = 3'd4
    } branch_t;

    // RISC-V funct3 encodings; 010 and 011 are undefined and resolve not-taken.
    typedef enum logic [2:0] {
        Beq  = 3'b000,
        Bne  = 3'b001,
        Blt  = 3'b100,
        Bge  = 3'b101,
        Bltu = 3'b110,
        Bgeu = 3'b111
    } cond_branch_t;
endpackage

module branch_resolve_predict_unit
    import branch_decoder_unit_pkg::*;
#(
    parameter int Width = 32,
    parameter int BhtDepth = 64,
    parameter logic [1:0] CounterInit = 2'b01,
    parameter int CntWidth = 32
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [Width-1:0]    pred_pc,
    output logic                pred_taken,
    input  logic                res_valid,
    input  logic                res_kill,
    input  logic [Width-1:0]    res_pc,
    input  branch_t             branch_type,
    input  cond_branch_t        cond_branch_type,
    input  logic                res_pred_taken,
    input  logic [Width-1:0]    read_data_1,
    input  logic [Width-1:0]    read_data_2,
    output logic                out_valid,
    output logic [1:0]          pc_src,
    output logic                mispredict,
    output logic [CntWidth-1:0] branch_cnt,
    output logic [CntWidth-1:0] mispredict_cnt
);
    localparam int IdxW = $clog2(BhtDepth);

    logic [1:0]       bht [BhtDepth];
    logic [IdxW-1:0]  pred_idx;
    logic [IdxW-1:0]  res_idx;
    logic [Width:0]   sum;
    logic [Width-1:0] diff;
    logic             carry;
    logic             eq;
    logic             lt;
    logic             ltu;
    logic             taken;
    logic             accept;
    logic             is_cond;
    logic [1:0]       ctr;
    logic [1:0]       ctr_next;
    logic [1:0]       pc_src_next;
    logic             mis_next;
    logic             unused_pc_bits;

    assign pred_idx = pred_pc[IdxW+1:2];
    assign res_idx  = res_pc[IdxW+1:2];
    assign unused_pc_bits = ^{pred_pc[Width-1:IdxW+2], pred_pc[1:0],
                              res_pc[Width-1:IdxW+2], res_pc[1:0]};

    // Registered BHT makes the lookup naturally read-before-write on an index collision.
    assign pred_taken = bht[pred_idx][1];

    // rd1 + ~rd2 + 1: carry out is set exactly when rd1 >= rd2 unsigned.
    assign sum   = {1'b0, read_data_1} + {1'b0, ~read_data_2} + {{Width{1'b0}}, 1'b1};
    assign diff  = sum[Width-1:0];
    assign carry = sum[Width];
    assign eq    = (diff == '0);
    assign lt    = diff[Width-1] ^ ((read_data_1[Width-1] ^ read_data_2[Width-1])
                                  & (read_data_1[Width-1] ^ diff[Width-1]));
    assign ltu   = ~carry;

    always_comb begin
        taken = 1'b0;
        case (cond_branch_type)
            Beq:     taken = eq;
            Bne:     taken = ~eq;
            Blt:     taken = lt;
            Bge:     taken = ~lt;
            Bltu:    taken = ltu;
            Bgeu:    taken = ~ltu;
            default: taken = 1'b0;
        endcase
    end

    assign accept  = res_valid & ~res_kill;
    assign is_cond = (branch_type == CondBranch);
    assign ctr     = bht[res_idx];

    always_comb begin
        ctr_next = taken ? ((ctr == 2'b11) ? 2'b11 : ctr + 2'd1)
                         : ((ctr == 2'b00) ? 2'b00 : ctr - 2'd1);
        pc_src_next = 2'b00;
        mis_next = 1'b0;
        case (branch_type)
            Mret: pc_src_next = 2'b01;
            Sret: pc_src_next = 2'b10;
            Jump: begin
                pc_src_next = 2'b11;
                mis_next = ~res_pred_taken;
            end
            CondBranch: begin
                pc_src_next = taken ? 2'b11 : 2'b00;
                mis_next = taken ^ res_pred_taken;
            end
            default: pc_src_next = 2'b00;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BhtDepth; i++) bht[i] <= CounterInit;
            out_valid      <= 1'b0;
            pc_src         <= 2'b00;
            mispredict     <= 1'b0;
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            out_valid  <= accept;
            pc_src     <= accept ? pc_src_next : 2'b00;
            mispredict <= accept & mis_next;
            if (accept && is_cond) bht[res_idx] <= ctr_next;
            if (accept && (is_cond || branch_type == Jump) && branch_cnt != '1)
                branch_cnt <= branch_cnt + CntWidth'(1);
            if (accept && mis_next && mispredict_cnt != '1)
                mispredict_cnt <= mispredict_cnt + CntWidth'(1);
        end
    end
endmodule

// File: tb/tb_branch_resolve_predict_unit.sv
// tb_branch_resolve_predict_unit: directed vectors with hand-computed expectations;
// counters are 4 bits wide so saturation is reached by real traffic.
module tb_branch_resolve_predict_unit;
    import branch_decoder_unit_pkg::*;

    logic         clock = 1'b0;
    logic         reset_n;
    logic [31:0]  pred_pc;
    logic         pred_taken;
    logic         res_valid;
    logic         res_kill;
    logic [31:0]  res_pc;
    branch_t      branch_type;
    cond_branch_t cond_branch_type;
    logic         res_pred_taken;
    logic [31:0]  read_data_1;
    logic [31:0]  read_data_2;
    logic         out_valid;
    logic [1:0]   pc_src;
    logic         mispredict;
    logic [3:0]   branch_cnt;
    logic [3:0]   mispredict_cnt;

    int errors = 0;
    int checks = 0;

    branch_resolve_predict_unit #(.CntWidth(4)) dut (
        .clock(clock), .reset_n(reset_n), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .res_valid(res_valid), .res_kill(res_kill), .res_pc(res_pc),
        .branch_type(branch_type), .cond_branch_type(cond_branch_type),
        .res_pred_taken(res_pred_taken), .read_data_1(read_data_1), .read_data_2(read_data_2),
        .out_valid(out_valid), .pc_src(pc_src), .mispredict(mispredict),
        .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic outs(input string tag, input logic v, input logic [1:0] ps, input logic m,
                        input logic [3:0] bc, input logic [3:0] mc);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
        check({tag, ".pc_src"}, 32'(pc_src), 32'(ps));
        check({tag, ".mispredict"}, 32'(mispredict), 32'(m));
        check({tag, ".branch_cnt"}, 32'(branch_cnt), 32'(bc));
        check({tag, ".mispredict_cnt"}, 32'(mispredict_cnt), 32'(mc));
    endtask

    task automatic setup(input branch_t bt, input cond_branch_t ct, input logic [31:0] a,
                         input logic [31:0] b, input logic pt, input logic [31:0] pc);
        @(negedge clock);
        res_valid = 1'b1;
        res_kill = 1'b0;
        branch_type = bt;
        cond_branch_type = ct;
        read_data_1 = a;
        read_data_2 = b;
        res_pred_taken = pt;
        res_pc = pc;
    endtask

    task automatic req(input branch_t bt, input cond_branch_t ct, input logic [31:0] a,
                       input logic [31:0] b, input logic pt, input logic [31:0] pc);
        setup(bt, ct, a, b, pt, pc);
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        @(negedge clock);
        res_valid = 1'b0;
        res_kill = 1'b0;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        pred_pc = 32'h100;
        res_valid = 1'b0;
        res_kill = 1'b0;
        res_pc = '0;
        branch_type = NoBranch;
        cond_branch_type = Beq;
        res_pred_taken = 1'b0;
        read_data_1 = '0;
        read_data_2 = '0;
        #12;
        check("rst.pred_taken", 32'(pred_taken), 32'd0);
        outs("rst", 1'b0, 2'b00, 1'b0, 4'd0, 4'd0);
        @(negedge clock);
        reset_n = 1'b1;
        idle();
        check("idle.out_valid", 32'(out_valid), 32'd0);

        req(CondBranch, Beq, 32'd5, 32'd5, 1'b0, 32'h100);
        outs("beq", 1'b1, 2'b11, 1'b1, 4'd1, 4'd1);
        check("beq.pred_taken", 32'(pred_taken), 32'd1);

        req(CondBranch, Blt, 32'h8000_0000, 32'd1, 1'b1, 32'h104);
        outs("blt", 1'b1, 2'b11, 1'b0, 4'd2, 4'd1);
        req(CondBranch, Bltu, 32'h8000_0000, 32'd1, 1'b0, 32'h108);
        outs("bltu", 1'b1, 2'b00, 1'b0, 4'd3, 4'd1);
        req(CondBranch, Bgeu, 32'hFFFF_FFFF, 32'd0, 1'b1, 32'h10C);
        outs("bgeu", 1'b1, 2'b11, 1'b0, 4'd4, 4'd1);
        req(CondBranch, Bge, 32'd1, 32'h8000_0000, 1'b1, 32'h110);
        outs("bge", 1'b1, 2'b11, 1'b0, 4'd5, 4'd1);
        req(CondBranch, Bne, 32'd5, 32'd5, 1'b1, 32'h114);
        outs("bne", 1'b1, 2'b00, 1'b1, 4'd6, 4'd2);
        req(CondBranch, cond_branch_t'(3'b010), 32'd5, 32'd5, 1'b0, 32'h118);
        outs("undef", 1'b1, 2'b00, 1'b0, 4'd7, 4'd2);
        req(Jump, Beq, 32'd0, 32'd0, 1'b0, 32'h11C);
        outs("jmp0", 1'b1, 2'b11, 1'b1, 4'd8, 4'd3);
        req(Jump, Beq, 32'd0, 32'd0, 1'b1, 32'h120);
        outs("jmp1", 1'b1, 2'b11, 1'b0, 4'd9, 4'd3);

        // Reset while a result is held: outputs and BHT clear without a clock edge.
        @(negedge clock);
        res_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        outs("midrst", 1'b0, 2'b00, 1'b0, 4'd0, 4'd0);
        check("midrst.pred_taken", 32'(pred_taken), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        pred_pc = 32'h200;
        setup(CondBranch, Beq, 32'd1, 32'd1, 1'b1, 32'h200);
        #1;
        check("rbw.pred_taken", 32'(pred_taken), 32'd0);
        @(posedge clock);
        #1;
        check("sat1.pred_taken", 32'(pred_taken), 32'd1);
        for (int i = 0; i < 4; i++) req(CondBranch, Beq, 32'd1, 32'd1, 1'b1, 32'h200);
        outs("sat5", 1'b1, 2'b11, 1'b0, 4'd5, 4'd0);
        check("sat5.pred_taken", 32'(pred_taken), 32'd1);
        req(CondBranch, Beq, 32'd1, 32'd2, 1'b1, 32'h200);
        check("dec1.pred_taken", 32'(pred_taken), 32'd1);
        req(CondBranch, Beq, 32'd1, 32'd2, 1'b1, 32'h200);
        check("dec2.pred_taken", 32'(pred_taken), 32'd0);
        outs("dec2", 1'b1, 2'b00, 1'b1, 4'd7, 4'd2);

        req(Mret, Beq, 32'd0, 32'd0, 1'b0, 32'h300);
        outs("mret", 1'b1, 2'b01, 1'b0, 4'd7, 4'd2);
        req(Sret, Beq, 32'd0, 32'd0, 1'b0, 32'h304);
        outs("sret", 1'b1, 2'b10, 1'b0, 4'd7, 4'd2);
        setup(CondBranch, Beq, 32'd1, 32'd1, 1'b0, 32'h200);
        res_kill = 1'b1;
        @(posedge clock);
        #1;
        outs("kill", 1'b0, 2'b00, 1'b0, 4'd7, 4'd2);
        check("kill.pred_taken", 32'(pred_taken), 32'd0);

        for (int i = 0; i < 16; i++) req(Jump, Beq, 32'd0, 32'd0, 1'b0, 32'h400);
        outs("cntsat", 1'b1, 2'b11, 1'b1, 4'hF, 4'hF);
        req(Jump, Beq, 32'd0, 32'd0, 1'b0, 32'h404);
        outs("cntsat2", 1'b1, 2'b11, 1'b1, 4'hF, 4'hF);
        idle();
        outs("final", 1'b0, 2'b00, 1'b0, 4'hF, 4'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
